// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Round-robin arbiter sharing one single-ported memory bus between
//            instruction fetch and the load/store path; one outstanding access.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [XLEN-1:0] if_rdata,
  input  logic            ls_req,
  input  logic            ls_we,
  input  logic [XLEN-1:0] ls_addr,
  input  logic [XLEN-1:0] ls_wdata,
  output logic            ls_gnt,
  output logic            ls_rvalid,
  output logic [XLEN-1:0] ls_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam logic [1:0] c_ST_IDLE    = 2'd0;
  localparam logic [1:0] c_ST_BUSY_IF = 2'd1;
  localparam logic [1:0] c_ST_BUSY_LS = 2'd2;

  logic [1:0] r_state;
  logic [1:0] w_next_state;
  logic       r_last_ls;
  logic       w_idle;
  logic       w_pick_ls;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (ls_gnt)      w_next_state = c_ST_BUSY_LS;
        else if (if_gnt) w_next_state = c_ST_BUSY_IF;
      end
      c_ST_BUSY_IF, c_ST_BUSY_LS: begin
        if (mem_ready) w_next_state = c_ST_IDLE;
      end
      default: w_next_state = c_ST_IDLE;
    endcase
  end

  // On contention the requester that did not win last time goes first
  always_comb begin
    w_idle    = (r_state == c_ST_IDLE);
    w_pick_ls = ls_req && (!if_req || !r_last_ls);
    ls_gnt    = rst_n && w_idle && w_pick_ls;
    if_gnt    = rst_n && w_idle && if_req && !w_pick_ls;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_ls <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      ls_rvalid <= 1'b0;
      ls_rdata  <= '0;
    end else begin
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      if (ls_gnt) begin
        mem_req   <= 1'b1;
        mem_we    <= ls_we;
        mem_addr  <= ls_addr;
        mem_wdata <= ls_wdata;
        r_last_ls <= 1'b1;
      end else if (if_gnt) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
        r_last_ls <= 1'b0;
      end else if (!w_idle && mem_ready) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
        if (r_state == c_ST_BUSY_IF) begin
          if_rvalid <= 1'b1;
          if_rdata  <= mem_rdata;
        end else begin
          // Stores complete with zero data so stale load data never leaks out
          ls_rvalid <= 1'b1;
          ls_rdata  <= mem_we ? '0 : mem_rdata;
        end
      end
    end
  end

endmodule
`default_nettype wire
